machine_seg_scan: RTL



---
 rtl/machine_seg_scan.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/machine_seg_scan.sv
// machine_seg_scan: time-multiplexes DIGITS hex digits onto one shared active-low segment bus.
// Define MACHINE_SEG_SCAN_DIM_EN to add a 4-bit brightness input with PWM anode dimming.
module machine_seg_scan #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 2,
  parameter int DIV    = 50000,
  parameter int CNT_W  = 16,
  parameter int BLANK  = 16
) (
  input  logic                  system1000,
  input  logic                  system1000_rstn,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  enable,
`ifdef MACHINE_SEG_SCAN_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [DIGITS-1:0]     anode_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  slot_tick
);

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]    r_presc;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_anode_n;
  logic [6:0]          r_seg_n;
  logic                r_dp_n;
  logic                r_tick;

  logic                w_wrap;
  logic [CNT_W-1:0]    w_presc_next;
  logic [IDX_W-1:0]    w_idx_next;
  logic [4*DIGITS-1:0] w_value_next;
  logic [DIGITS-1:0]   w_dp_next;
  logic [3:0]          w_nibble;
  logic                w_dp_sel;
  logic                w_blank;
  logic                w_lit;
  logic [DIGITS-1:0]   w_anode_next;
  logic [6:0]          w_seg_next;
  logic                w_dpn_next;
  logic                w_tick_next;

  assign w_wrap = (r_presc == CNT_W'(DIV - 1));

  // Outputs are computed from the next state so anode, segments and index all move on one edge.
  always_comb begin
    w_presc_next = r_presc;
    w_idx_next   = r_idx;
    if (enable) begin
      if (w_wrap) begin
        w_presc_next = '0;
        w_idx_next   = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        w_presc_next = r_presc + CNT_W'(1);
      end
    end
  end

  assign w_value_next = load ? value : r_value;
  assign w_dp_next    = load ? dp    : r_dp;

  always_comb begin
    w_nibble = '0;
    w_dp_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_idx_next == IDX_W'(k)) begin
        w_nibble = w_value_next[4*k +: 4];
        w_dp_sel = w_dp_next[k];
      end
    end
  end

  generate
    if (BLANK > 0) begin : g_blank
      assign w_blank = (w_presc_next < CNT_W'(BLANK));
    end else begin : g_noblank
      assign w_blank = 1'b0;
    end
  endgenerate

`ifdef MACHINE_SEG_SCAN_DIM_EN
  logic [3:0] r_pwm;
  logic [3:0] w_pwm_next;

  assign w_pwm_next = enable ? r_pwm + 4'd1 : r_pwm;
  assign w_lit      = !w_blank && (w_pwm_next <= brightness);

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= w_pwm_next;
    end
  end
`else
  assign w_lit = !w_blank;
`endif

  always_comb begin
    w_tick_next  = enable & w_wrap;
    w_anode_next = '1;
    w_seg_next   = 7'h7F;
    w_dpn_next   = 1'b1;
    if (enable) begin
      w_anode_next = w_lit ? ~(DIGITS'(1) << w_idx_next) : '1;
      w_seg_next   = f_decode(w_nibble);
      w_dpn_next   = ~w_dp_sel;
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_presc   <= '0;
      r_idx     <= '0;
      r_value   <= '0;
      r_dp      <= '0;
      r_anode_n <= '1;
      r_seg_n   <= 7'h7F;
      r_dp_n    <= 1'b1;
      r_tick    <= 1'b0;
    end else begin
      r_presc   <= w_presc_next;
      r_idx     <= w_idx_next;
      r_value   <= w_value_next;
      r_dp      <= w_dp_next;
      r_anode_n <= w_anode_next;
      r_seg_n   <= w_seg_next;
      r_dp_n    <= w_dpn_next;
      r_tick    <= w_tick_next;
    end
  end

  assign anode_n   = r_anode_n;
  assign seg_n     = r_seg_n;
  assign dp_n      = r_dp_n;
  assign digit_idx = r_idx;
  assign slot_tick = r_tick;

endmodule
